inst_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the instruction decoder/analyser.

---
 rtl/inst_fetch_unit.sv | 128 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, instruction FIFO, redirect squash
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, BUSY, SQUASH} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt, addr_nxt;
  logic [31:0]        redirect_tgt;
  logic [31:0]        fifo_pc [FIFO_DEPTH];
  logic [31:0]        fifo_ir [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count, count_post;
  logic               push, pop;

  // Redirect target is always word aligned; the low address bits are dropped.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // A redirect kills both the returning word and any same-cycle pop.
  assign push       = (state == BUSY) && imem_ack && !redirect;
  assign pop        = id_valid && id_ready && !redirect;
  assign count_post = count + CNT_W'(push) - CNT_W'(pop);

  assign imem_req = (state != IDLE);
  assign id_valid = (count != '0);
  assign id_ir    = id_valid ? fifo_ir[rd_ptr] : NOP_INST;
  assign id_pc    = id_valid ? fifo_pc[rd_ptr] : 32'h0;

  // Next state, next pc and next request address; redirect overrides the normal flow.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = imem_addr;
    case (state)
      IDLE: begin
        if (count < CNT_W'(FIFO_DEPTH)) begin
          state_nxt = BUSY;
          addr_nxt  = pc;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          pc_nxt = imem_addr + 32'd4;
          if (count_post < CNT_W'(FIFO_DEPTH)) begin
            addr_nxt = imem_addr + 32'd4;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SQUASH: begin
        if (imem_ack) begin
          state_nxt = BUSY;
          addr_nxt  = pc;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      pc_nxt = redirect_tgt;
      if (state == IDLE || imem_ack) begin
        state_nxt = BUSY;
        addr_nxt  = redirect_tgt;
      end else begin
        state_nxt = SQUASH;
        addr_nxt  = imem_addr;
      end
    end
  end

  // FSM state, program counter and the outstanding request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imem_addr <= addr_nxt;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_post;
    end
  end

  // FIFO storage: returned word tagged with the address it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr] <= imem_addr;
      fifo_ir[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - randomized self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_pc;

  logic        w_req, w_ack, w_valid;
  logic [31:0] w_addr, w_rdata, w_ir, w_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  int          lat_mode = 0;
  int          mem_lat = 0;
  bit          mem_busy = 0;
  logic [31:0] key = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  bit          flush_chk = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_pc(id_pc)
  );

  assign w_ack   = w_req;
  assign w_rdata = w_addr;

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .NOP_INST(NOP_INST)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(w_valid), .id_ready(1'b1), .id_ir(w_ir), .id_pc(w_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_mem();
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_lat  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      imem_ack   = (mem_lat == 0);
      imem_rdata = imem_addr ^ key;
      if (mem_lat == 0) mem_busy = 0;
      else mem_lat--;
    end else begin
      imem_ack = 1'b0;
      mem_busy = 0;
    end
  endtask

  // Sample mid-cycle, check against the stream model, advance to posedge+1.
  task automatic cycle();
    #3;
    if (!rst_n) begin
      exp_pc    = RESET_PC;
      flush_chk = 0;
      prev_hold = 0;
      wq.delete();
    end else begin
      if (flush_chk) check("flush", id_valid, 1'b0);
      if (!id_valid) begin
        check("nop_ir", id_ir, NOP_INST);
        check("nop_pc", id_pc, 32'h0);
      end
      if (prev_hold) begin
        check("req_hold", imem_req, 1'b1);
        check("addr_hold", imem_addr, prev_addr);
      end
      if (id_valid && id_ready && !redirect) begin
        check("id_pc", id_pc, exp_pc);
        check("id_ir", id_ir, exp_pc ^ key);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      flush_chk = redirect;
      prev_hold = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (w_req && w_ack && wq.size() < 3) wq.push_back(w_addr);
    end
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!id_valid && n < 30) begin
      cycle();
      n++;
    end
    check(tag, id_valid, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;

    // Test 1: zero-wait streaming, plus reset state
    lat_mode = 0;
    rst_n = 1'b0;
    cycle();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", id_valid, 1'b0);
    check("rst_ir", id_ir, NOP_INST);
    check("rst_pc", id_pc, 32'h0);
    do_reset();
    cycle();
    for (int k = 1; k <= 6; k++) begin
      check("t1_req", imem_req, 1'b1);
      check("t1_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) begin
        check("t1_valid", id_valid, 1'b1);
        check("t1_pc", id_pc, 32'(4 * (k - 2)));
        check("t1_ir", id_ir, id_pc);
      end
      cycle();
    end

    // Test 5: second instance fetching across the 32-bit wrap
    check("t5_cnt", 32'(wq.size()), 32'd3);
    if (wq.size() >= 3) begin
      check("t5_a0", wq[0], 32'hFFFF_FFF8);
      check("t5_a1", wq[1], 32'hFFFF_FFFC);
      check("t5_a2", wq[2], 32'h0000_0000);
    end

    // Test 2: backpressure fills the FIFO, fetch stops, then resumes at 8
    id_ready = 1'b0;
    do_reset();
    cycle(); cycle(); cycle();
    check("t2_idle", imem_req, 1'b0);
    check("t2_head", id_pc, 32'h0);
    cycle();
    id_ready = 1'b1;
    check("t2_pop0", id_pc, 32'h0);
    cycle();
    check("t2_pop1", id_pc, 32'h4);
    check("t2_idle2", imem_req, 1'b0);
    cycle();
    check("t2_req", imem_req, 1'b1);
    check("t2_addr", imem_addr, 32'h8);
    cycle(); cycle();

    // Test 3: redirect while a slow request is outstanding
    lat_mode = 3;
    do_reset();
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("t3_hold_a", imem_addr, 32'h0);
    cycle();
    check("t3_hold_b", imem_addr, 32'h0);
    check("t3_ack", imem_ack, 1'b1);
    cycle();
    check("t3_req", imem_req, 1'b1);
    check("t3_new", imem_addr, 32'h100);
    wait_valid("t3_wait");
    check("t3_first", id_pc, 32'h100);

    // Test 4: redirect with same-cycle ack and a FIFO entry pending
    lat_mode = 0; id_ready = 1'b0;
    do_reset();
    cycle(); cycle();
    check("t4_pre", id_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0;
    check("t4_empty", id_valid, 1'b0);
    check("t4_addr", imem_addr, 32'h200);
    id_ready = 1'b1;
    wait_valid("t4_wait");
    check("t4_first", id_pc, 32'h200);

    // Test 6: asynchronous reset in the middle of an outstanding request
    lat_mode = 3;
    do_reset();
    cycle(); cycle();
    #1 rst_n = 1'b0;
    #1;
    check("t6_req", imem_req, 1'b0);
    check("t6_addr", imem_addr, RESET_PC);
    check("t6_valid", id_valid, 1'b0);
    check("t6_ir", id_ir, NOP_INST);
    cycle();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    lat_mode = 0;
    cycle();
    check("t6_restart", imem_addr, RESET_PC);
    check("t6_rreq", imem_req, 1'b1);
    check("t6_novalid", id_valid, 1'b0);
    wait_valid("t6_wait");
    check("t6_first", id_pc, RESET_PC);

    // Randomized phase: random latency, backpressure and redirects
    lat_mode = -1;
    do_reset();
    key = $urandom;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      id_ready    = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    redirect = 1'b0;
    check("progress", (n_deliv > 200), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
